// File: rtl/reg_wdec_file_pkg.sv
// Shared FSM state encoding and default widths for the register file.
// Optional same-cycle write bypass is enabled by defining REG_WDEC_FILE_BYPASS_EN.
package reg_wdec_file_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/reg_wdec.sv
// One-hot write-address decoder; all-zero when the enable is low.
// Latency: combinational. Backpressure: none.
module reg_wdec #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   en,
  output logic [(2**ADDR_W)-1:0] onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_wdec_file.sv
// Register file: 1 write and 2 combinational read ports, bulk clear sweep, registered write one-hot.
// Read latency 0, write visible next cycle (same cycle if REG_WDEC_FILE_BYPASS_EN); writes dropped while clearing.
module reg_wdec_file
  import reg_wdec_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   iWe,
  input  logic [ADDR_W-1:0]      iWAddr,
  input  logic [DATA_W-1:0]      iWData,
  input  logic [ADDR_W-1:0]      iRAddr1,
  input  logic [ADDR_W-1:0]      iRAddr2,
  output logic [DATA_W-1:0]      oRData1,
  output logic [DATA_W-1:0]      oRData2,
  input  logic                   iClr,
  output logic                   oBusy,
  output logic [(2**ADDR_W)-1:0] oWeVec
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic                busy_q, busy_d;
  logic [NREG-1:0]     we_vec, we_vec_q;
  logic [DATA_W-1:0]   mem_q [NREG];
  logic [DATA_W-1:0]   mem_d [NREG];
  logic                zero_hit;
  logic                we_acc;

  // Clear wins over a simultaneous write; reset wins over everything.
  assign zero_hit = (ZERO_REG != 0) && (iWAddr == '0);
  assign we_acc   = !rst && iWe && !iClr && (state_q == IDLE) && !zero_hit;

  reg_wdec #(.ADDR_W(ADDR_W)) u_wdec (
    .addr   (iWAddr),
    .en     (we_acc),
    .onehot (we_vec)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mem_d   = mem_q;
    for (int i = 0; i < NREG; i++) begin
      if (we_vec[i]) mem_d[i] = iWData;
    end
    unique case (state_q)
      IDLE: begin
        if (iClr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[idx_q] = '0;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      we_vec_q <= '0;
      for (int i = 0; i < NREG; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      we_vec_q <= we_vec;
      for (int i = 0; i < NREG; i++) mem_q[i] <= mem_d[i];
    end
  end

  always_comb begin
    oRData1 = mem_q[iRAddr1];
    oRData2 = mem_q[iRAddr2];
`ifdef REG_WDEC_FILE_BYPASS_EN
    if (we_acc && (iRAddr1 == iWAddr)) oRData1 = iWData;
    if (we_acc && (iRAddr2 == iWAddr)) oRData2 = iWData;
`endif
    if ((ZERO_REG != 0) && (iRAddr1 == '0)) oRData1 = '0;
    if ((ZERO_REG != 0) && (iRAddr2 == '0)) oRData2 = '0;
  end

  assign oBusy  = busy_q;
  assign oWeVec = we_vec_q;

endmodule

// File: tb/tb_reg_wdec_file.sv
// Bench for reg_wdec_file: directed table, clear/collision/reset sequences, and random traffic against a model.
// Expected bypass behaviour follows REG_WDEC_FILE_BYPASS_EN.
module tb_reg_wdec_file;

`ifdef REG_WDEC_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        iWe;
  logic [4:0]  iWAddr;
  logic [31:0] iWData;
  logic [4:0]  iRAddr1, iRAddr2;
  logic [31:0] oRData1, oRData2;
  logic        iClr;
  logic        oBusy;
  logic [31:0] oWeVec;

  always #5 clk = ~clk;

  reg_wdec_file dut (
    .clk(clk), .rst(rst), .iWe(iWe), .iWAddr(iWAddr), .iWData(iWData),
    .iRAddr1(iRAddr1), .iRAddr2(iRAddr2), .oRData1(oRData1), .oRData2(oRData2),
    .iClr(iClr), .oBusy(oBusy), .oWeVec(oWeVec)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference model: array contents plus a count of clear cycles still to run.
  logic [31:0] mdl [32];
  int          clr_left;
  logic [31:0] exp_wevec;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mdl_read(input logic [4:0] a);
    if (a == 0) return 32'h0;
    if (BYP && !rst && clr_left == 0 && iWe && !iClr && iWAddr == a) return iWData;
    return mdl[a];
  endfunction

  function automatic void model_edge();
    exp_wevec = 32'h0;
    if (rst) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      clr_left = 0;
    end else if (clr_left > 0) begin
      mdl[32 - clr_left] = 32'h0;
      clr_left--;
    end else if (iClr) begin
      clr_left = 32;
    end else if (iWe && iWAddr != 0) begin
      mdl[iWAddr] = iWData;
      exp_wevec = 32'h1 << iWAddr;
    end
  endfunction

  task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic clr, input logic rs, input logic [4:0] a1, input logic [4:0] a2);
    iWe = we; iWAddr = wa; iWData = wd; iClr = clr; rst = rs; iRAddr1 = a1; iRAddr2 = a2;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // One model-checked cycle: reads before the edge, registered outputs after it.
  task automatic cyc(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                     input logic clr, input logic rs, input logic [4:0] a1, input logic [4:0] a2);
    drive(we, wa, wd, clr, rs, a1, a2);
    check("rdata1", oRData1, mdl_read(a1));
    check("rdata2", oRData2, mdl_read(a2));
    edge_step();
    check("busy", {31'h0, oBusy}, {31'h0, clr_left > 0});
    check("wevec", oWeVec, exp_wevec);
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2, ewv;
  } vec_t;

  vec_t tbl [9];
  int   n;

  initial begin
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd5,  BYP ? 32'hDEADBEEF : 32'h0, BYP ? 32'hDEADBEEF : 32'h0, 32'h0000_0020};
    tbl[1] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd0,  32'hDEADBEEF, 32'h0,        32'h0};
    tbl[2] = '{1'b1, 5'd0,  32'h12345678, 5'd0,  5'd5,  32'h0,        32'hDEADBEEF, 32'h0};
    tbl[3] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0};
    tbl[4] = '{1'b1, 5'd7,  32'h11111111, 5'd7,  5'd1,  BYP ? 32'h11111111 : 32'h0, 32'h0, 32'h0000_0080};
    tbl[5] = '{1'b1, 5'd7,  32'hA5A5A5A5, 5'd7,  5'd7,  BYP ? 32'hA5A5A5A5 : 32'h11111111, BYP ? 32'hA5A5A5A5 : 32'h11111111, 32'h0000_0080};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd5,  32'hA5A5A5A5, 32'hDEADBEEF, 32'h0};
    tbl[7] = '{1'b1, 5'd31, 32'hCAFEF00D, 5'd31, 5'd1,  BYP ? 32'hCAFEF00D : 32'h0, 32'h0, 32'h8000_0000};
    tbl[8] = '{1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'hCAFEF00D, 32'hCAFEF00D, 32'h0};

    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    clr_left = 0;
    exp_wevec = 32'h0;

    // Reset state
    drive(1'b1, 5'd4, 32'hFFFFFFFF, 1'b1, 1'b1, 5'd4, 5'd0);
    edge_step();
    edge_step();
    check("reset_busy", {31'h0, oBusy}, 32'h0);
    check("reset_wevec", oWeVec, 32'h0);
    check("reset_rd", oRData1, 32'h0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, 1'b0, 1'b0, tbl[i].a1, tbl[i].a2);
      check("tbl_rd1", oRData1, tbl[i].e1);
      check("tbl_rd2", oRData2, tbl[i].e2);
      edge_step();
      check("tbl_wevec", oWeVec, tbl[i].ewv);
      check("tbl_busy", {31'h0, oBusy}, 32'h0);
    end

    // Bulk clear with a dropped mid-clear write and an ignored re-clear
    for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'h01010101 * i + 32'h1, 1'b0, 1'b0, 5'(i), 5'(i));
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd1, 5'd31);
    n = 0;
    while (oBusy && n < 100) begin
      n++;
      cyc(n == 10, 5'd30, 32'hFFFF0000, n == 5, 1'b0, 5'(n), 5'd31);
    end
    check("clear_busy_cycles", n, 32);
    for (int i = 0; i < 32; i++) cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'(i), 5'(31 - i));
    for (int i = 0; i < 32; i += 2) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'(i), 5'(i + 1));
      check("post_clear_zero1", oRData1, 32'h0);
      check("post_clear_zero2", oRData2, 32'h0);
    end

    // Collision: clear wins over a write in the same cycle
    cyc(1'b1, 5'd3, 32'h33333333, 1'b0, 1'b0, 5'd3, 5'd3);
    cyc(1'b1, 5'd3, 32'h44444444, 1'b1, 1'b0, 5'd3, 5'd3);
    check("collision_wevec", oWeVec, 32'h0);
    n = 0;
    while (oBusy && n < 100) begin
      n++;
      cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd2);
    end
    drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd3, 5'd3);
    check("collision_reg3", oRData1, 32'h0);

    // Reset at clear cycle 10
    for (int i = 1; i < 32; i++) cyc(1'b1, 5'(i), 32'hF0000000 | i, 1'b0, 1'b0, 5'(i), 5'd0);
    cyc(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd20, 5'd1);
    cyc(1'b1, 5'd20, 32'h5, 1'b1, 1'b1, 5'd20, 5'd12);
    check("rst_mid_busy", {31'h0, oBusy}, 32'h0);
    cyc(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 5'd0);
    check("rst_mid_idle", {31'h0, oBusy}, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'(i), 5'(i));
      check("rst_mid_zero", oRData1, 32'h0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 2) != 0, 5'($urandom), $urandom,
          $urandom_range(0, 60) == 0, $urandom_range(0, 250) == 0,
          5'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
